// File: rtl/dvs_ravens_pkg.sv
// rtl/dvs_ravens_pkg.sv - shared DVS AER widths, event type, FSM encoding and word builders
// Purpose: common definitions for the DVS AER transmitter/receiver pair.
// Contents: address widths, AER bus width, dvs_event_t, transmitter FSM
//           states, and helpers that pack Y and X/polarity words onto the bus.
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS = 7;
  localparam int DVS_Y_ADDR_BITS = 7;
  localparam int AER_BUS_BITS    = 10;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0] x;
    logic [DVS_Y_ADDR_BITS-1:0] y;
    logic                       polarity;
  } dvs_event_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SETUP       = 2'd1,
    ST_REQ_ASSERT  = 2'd2,
    ST_REQ_RELEASE = 2'd3
  } aer_tx_state_t;

  // Y word: row address in the low bits, remaining bits zero.
  function automatic logic [AER_BUS_BITS-1:0] aer_y_word(input logic [DVS_Y_ADDR_BITS-1:0] y);
    logic [AER_BUS_BITS-1:0] w;
    w = '0;
    w[DVS_Y_ADDR_BITS-1:0] = y;
    return w;
  endfunction

  // X word: column above the polarity bit, remaining bits zero.
  function automatic logic [AER_BUS_BITS-1:0] aer_x_word(input logic [DVS_X_ADDR_BITS-1:0] x,
                                                         input logic                       pol);
    logic [AER_BUS_BITS-1:0] w;
    w = '0;
    w[DVS_X_ADDR_BITS:1] = x;
    w[0] = pol;
    return w;
  endfunction

endpackage

// File: rtl/dvs_aer_transmitter_if.sv
// rtl/dvs_aer_transmitter_if.sv - event input and AER bus bundle for the DVS AER transmitter
// Purpose: groups the event valid/ready port, the AER bus and the status flags.
// Signals: in_valid/in_ready/in_x/in_y/in_polarity (event in), aer/xsel/req/ack
//          (AER 4-phase bus), busy/ack_timeout (status).
// Modports: master = transmitter side, slave = event source / AER receiver side.
interface dvs_aer_transmitter_if;
  import dvs_ravens_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [DVS_X_ADDR_BITS-1:0] in_x;
  logic [DVS_Y_ADDR_BITS-1:0] in_y;
  logic                       in_polarity;
  logic [AER_BUS_BITS-1:0]    aer;
  logic                       xsel;
  logic                       req;
  logic                       ack;
  logic                       busy;
  logic                       ack_timeout;

  modport master (
    input  in_valid, in_x, in_y, in_polarity, ack,
    output in_ready, aer, xsel, req, busy, ack_timeout
  );

  modport slave (
    output in_valid, in_x, in_y, in_polarity, ack,
    input  in_ready, aer, xsel, req, busy, ack_timeout
  );

endinterface

// File: rtl/dvs_sync_2ff.sv
// rtl/dvs_sync_2ff.sv - two-flop synchroniser for asynchronous level inputs
// Purpose: brings asynchronous level signals into the clk domain.
// Ports: clk (clock), rst (async active-high reset, clears both stages),
//        d (asynchronous input), q (synchronised output, two cycles of latency).
module dvs_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dvs_aer_transmitter.sv
// rtl/dvs_aer_transmitter.sv - DVS AER 4-phase sender with row grouping and ack timeout
// Purpose: accepts (x, y, polarity) events and sends each one as an optional Y word
//          followed by an X/polarity word on the AER bus, skipping Y when the row repeats.
// Ports: clk (clock), rst (async active-high reset),
//        bus (master modport): in_valid/in_ready/in_x/in_y/in_polarity event input,
//        aer/xsel/req out and ack in for the AER handshake, busy and sticky ack_timeout.
module dvs_aer_transmitter
  import dvs_ravens_pkg::*;
#(
  parameter int SETUP_CYCLES       = 4,
  parameter int ACK_TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  dvs_aer_transmitter_if.master bus
);

  localparam int CNT_MAX = (SETUP_CYCLES > ACK_TIMEOUT_CYCLES) ? SETUP_CYCLES : ACK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'((ACK_TIMEOUT_CYCLES == 0) ? 0 : ACK_TIMEOUT_CYCLES - 1);
  localparam bit TMO_ENABLED = (ACK_TIMEOUT_CYCLES != 0);

  aer_tx_state_t              state, state_next;
  logic [CNT_W-1:0]           cnt;
  logic [0:0]                 ack_synced;
  dvs_event_t                 ev_q;
  logic [DVS_Y_ADDR_BITS-1:0] last_y;
  logic                       last_y_valid;
  logic [AER_BUS_BITS-1:0]    aer_q;
  logic                       xsel_q;
  logic                       req_q;
  logic                       ack_timeout_q;

  logic in_ready_c;
  logic busy_c;
  logic accept;
  logic send_y;
  logic y_done;
  logic timeout_hit;
  logic timeout_evt;

  dvs_sync_2ff #(.WIDTH(1)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ack),
    .q   (ack_synced)
  );

  assign timeout_hit = TMO_ENABLED && (cnt == TMO_LAST);
  assign send_y      = !last_y_valid || (bus.in_y != last_y);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:        if (accept) state_next = ST_SETUP;
      ST_SETUP:       if (cnt == SETUP_LAST) state_next = ST_REQ_ASSERT;
      ST_REQ_ASSERT: begin
        if (ack_synced[0])    state_next = ST_REQ_RELEASE;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_REQ_RELEASE: begin
        // An X word closes the event; a Y word is followed by its X word.
        if (!ack_synced[0])   state_next = xsel_q ? ST_IDLE : ST_SETUP;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      default:        state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    // IDLE refuses new events while a stale ack (left over after a timeout) is still high.
    in_ready_c  = (state == ST_IDLE) && !ack_synced[0] && !rst;
    busy_c      = (state != ST_IDLE);
    accept      = bus.in_valid && in_ready_c;
    y_done      = (state == ST_REQ_RELEASE) && !ack_synced[0] && !xsel_q;
    timeout_evt = ((state == ST_REQ_ASSERT)  && !ack_synced[0] && timeout_hit) ||
                  ((state == ST_REQ_RELEASE) &&  ack_synced[0] && timeout_hit);
  end

  // Shared setup/timeout counter: restarts on every state change, saturates otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Datapath: latched event, bus word, row register, registered req and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_q          <= '0;
      aer_q         <= '0;
      xsel_q        <= 1'b0;
      req_q         <= 1'b0;
      last_y        <= '0;
      last_y_valid  <= 1'b0;
      ack_timeout_q <= 1'b0;
    end else begin
      req_q <= (state_next == ST_REQ_ASSERT);
      if (accept) begin
        ev_q.x        <= bus.in_x;
        ev_q.y        <= bus.in_y;
        ev_q.polarity <= bus.in_polarity;
        if (send_y) begin
          aer_q  <= aer_y_word(bus.in_y);
          xsel_q <= 1'b0;
        end else begin
          aer_q  <= aer_x_word(bus.in_x, bus.in_polarity);
          xsel_q <= 1'b1;
        end
      end
      if (y_done) begin
        last_y       <= ev_q.y;
        last_y_valid <= 1'b1;
        aer_q        <= aer_x_word(ev_q.x, ev_q.polarity);
        xsel_q       <= 1'b1;
      end
      // The receiver may have seen a partial event, so the next event restarts with its row.
      if (timeout_evt) begin
        last_y_valid  <= 1'b0;
        ack_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.busy        = busy_c;
  assign bus.aer         = aer_q;
  assign bus.xsel        = xsel_q;
  assign bus.req         = req_q;
  assign bus.ack_timeout = ack_timeout_q;

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
// tb/tb_dvs_aer_transmitter.sv - directed and loopback bench for dvs_aer_transmitter
module tb_dvs_aer_transmitter;
  import dvs_ravens_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  dvs_aer_transmitter_if bus();

  int checks   = 0;
  int failures = 0;

  dvs_aer_transmitter #(
    .SETUP_CYCLES       (4),
    .ACK_TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Responsive ack model, AER receiver model and bus monitor.
  bit                      ack_en = 1'b1;
  logic                    d1 = 1'b0, d2 = 1'b0;
  logic [AER_BUS_BITS-1:0] prev_aer = '0;
  logic                    prev_xsel = 1'b0;
  logic                    prev_req = 1'b0;
  int                      since = 0;
  int                      hold_viol = 0;
  int                      req_len = 0;
  logic [DVS_Y_ADDR_BITS-1:0] rx_y = '0;
  logic [10:0] words[$];
  int          rise_gaps[$];
  logic [14:0] rx_q[$];

  always @(negedge clk) begin
    if ((bus.aer !== prev_aer) || (bus.xsel !== prev_xsel)) begin
      since = 0;
      if (bus.req || bus.ack) hold_viol++;
    end else if (since < 1000) begin
      since++;
    end
    if (bus.req && !prev_req) begin
      rise_gaps.push_back(since);
      words.push_back({bus.xsel, bus.aer});
      req_len = 0;
      if (!bus.xsel) rx_y = bus.aer[DVS_Y_ADDR_BITS-1:0];
      else           rx_q.push_back({rx_y, bus.aer[DVS_X_ADDR_BITS:1], bus.aer[0]});
    end
    if (bus.req) req_len++;
    prev_aer  = bus.aer;
    prev_xsel = bus.xsel;
    prev_req  = bus.req;
    if (rst) begin
      d1 = 1'b0;
      d2 = 1'b0;
    end else begin
      d2 = d1;
      d1 = bus.req;
    end
    bus.ack = ack_en & d2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] word_at(input int i);
    if (i < words.size()) return words[i];
    return 'x;
  endfunction

  task automatic send_event(input logic [6:0] x, input logic [6:0] y, input logic p);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.in_x        = x;
    bus.in_y        = y;
    bus.in_polarity = p;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic expect_words(input string tag, input int n, input logic [10:0] w0, input logic [10:0] w1);
    chk({tag, "_count"}, words.size(), n);
    chk({tag, "_w0"}, {21'd0, word_at(0)}, {21'd0, w0});
    if (n > 1) chk({tag, "_w1"}, {21'd0, word_at(1)}, {21'd0, w1});
  endtask

  initial begin
    logic [6:0]  rx, ry;
    logic        rp;
    logic [14:0] got;
    int          n;

    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_polarity = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_aer", {22'd0, bus.aer}, 32'd0);
    chk("rst_xsel", {31'd0, bus.xsel}, 32'd0);
    chk("rst_ack_timeout", {31'd0, bus.ack_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    words.delete();
    rise_gaps.delete();
    hold_viol = 0;

    // First event after reset: Y word then X word
    send_event(7'd5, 7'd3, 1'b1);
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    wait_idle("e1_idle");
    expect_words("e1", 2, 11'h003, 11'h40B);

    // Same row: X word only
    words.delete();
    send_event(7'd6, 7'd3, 1'b0);
    wait_idle("e2_idle");
    expect_words("e2", 1, 11'h40C, 11'h000);

    // Row change: Y word again
    words.delete();
    send_event(7'd6, 7'd4, 1'b0);
    wait_idle("e3_idle");
    expect_words("e3", 2, 11'h004, 11'h40C);

    // Setup spacing and data stability over the three events
    chk("gap_count", rise_gaps.size(), 5);
    for (int i = 0; i < rise_gaps.size(); i++) chk($sformatf("setup_gap%0d", i), rise_gaps[i], 4);
    chk("hold_violations", hold_viol, 0);
    chk("no_timeout_yet", {31'd0, bus.ack_timeout}, 32'd0);

    // Ack tied low: timeout (same row, so X word only)
    ack_en = 1'b0;
    words.delete();
    send_event(7'd1, 7'd4, 1'b0);
    wait_idle("tmo_idle");
    expect_words("tmo", 1, 11'h402, 11'h000);
    chk("tmo_req_low", {31'd0, bus.req}, 32'd0);
    chk("tmo_flag", {31'd0, bus.ack_timeout}, 32'd1);
    chk("tmo_req_len", req_len, 16);
    repeat (3) @(negedge clk);
    ack_en = 1'b1;

    // After timeout the row must be re-sent even though it repeats
    words.delete();
    send_event(7'd2, 7'd4, 1'b1);
    wait_idle("post_tmo_idle");
    expect_words("post_tmo", 2, 11'h004, 11'h405);
    chk("tmo_sticky", {31'd0, bus.ack_timeout}, 32'd1);

    // Reset during REQ_ASSERT
    words.delete();
    send_event(7'd3, 7'd4, 1'b0);
    n = 0;
    while (bus.req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_before_reset", {31'd0, bus.req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, bus.req}, 32'd0);
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("async_rst_flag", {31'd0, bus.ack_timeout}, 32'd0);
    chk("async_rst_aer", {22'd0, bus.aer}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    words.delete();
    send_event(7'd3, 7'd4, 1'b1);
    wait_idle("post_rst_idle");
    expect_words("post_rst", 2, 11'h004, 11'h407);

    // Loopback through the receiver model
    rx_q.delete();
    for (int i = 0; i < 100; i++) begin
      rx = 7'($urandom_range(0, 127));
      ry = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
      rp = 1'($urandom_range(0, 1));
      send_event(rx, ry, rp);
      wait_idle("loop_idle");
      got = (rx_q.size() == 1) ? rx_q.pop_front() : 'x;
      rx_q.delete();
      chk($sformatf("loop%0d", i), {17'd0, got}, {17'd0, ry, rx, rp});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
